// File: rtl/death_screen_ctrl.sv
// death_screen_ctrl: game-state controller feeding the death-screen text overlay.
// Tracks lives from collision pulses, sequences PLAY -> INVULN -> DYING -> DEAD
// -> RESTART, and restarts on an armed Enter keypress.
// Optional feature macro: DEATH_BLINK_EN (Death_Text blinks while DEAD).
// All outputs are registered; RESET is synchronous and active-low.

module death_screen_ctrl #(
    parameter int         LIVES         = 3,
    parameter int         INVULN_FRAMES = 60,
    parameter int         DYING_FRAMES  = 90,
    parameter logic [7:0] ENTER_KEY     = 8'h28,
    parameter int         BLINK_FRAMES  = 30
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       frame_tick,
    input  logic       player_hit,
    input  logic [7:0] keycode,
    output logic       Death_Text,
    output logic       game_active,
    output logic       invuln,
    output logic       game_reset,
    output logic [1:0] lives
);

    localparam logic [2:0] ST_PLAY    = 3'd0;
    localparam logic [2:0] ST_INVULN  = 3'd1;
    localparam logic [2:0] ST_DYING   = 3'd2;
    localparam logic [2:0] ST_DEAD    = 3'd3;
    localparam logic [2:0] ST_RESTART = 3'd4;

    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES);
    localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES);
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES);

`ifdef DEATH_BLINK_EN
    localparam logic BLINK_EN = 1'b1;
`else
    localparam logic BLINK_EN = 1'b0;
`endif

    logic [2:0] state_r;
    logic [2:0] state_s;
    logic [1:0] lives_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic [7:0] cnt_inc_s;
    logic       armed_r;
    logic       armed_s;
    logic       blink_r;
    logic       blink_s;
    logic       dead_text_s;

    assign cnt_inc_s = cnt_r + 8'd1;

    // Next-state, lives, frame counter, Enter arming and blink phase.
    always_comb begin
        state_s = state_r;
        lives_s = lives;
        cnt_s   = cnt_r;
        armed_s = armed_r;
        blink_s = blink_r;
        case (state_r)
            ST_PLAY: begin
                cnt_s = 8'd0;
                if (player_hit) begin
                    if (lives > 2'd1) begin
                        lives_s = lives - 2'd1;
                        state_s = ST_INVULN;
                    end else begin
                        lives_s = 2'd0;
                        state_s = ST_DYING;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_INVULN: begin
                // Hits are ignored here, including one coincident with the final tick.
                if (frame_tick) begin
                    if (cnt_inc_s == INVULN_LAST) begin
                        state_s = ST_PLAY;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (cnt_inc_s == DYING_LAST) begin
                        state_s = ST_DEAD;
                        cnt_s   = 8'd0;
                        armed_s = 1'b0;
                        blink_s = 1'b1;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DEAD: begin
                // Blink phase first so that a restart below can still clear the counter.
                if (BLINK_EN && frame_tick) begin
                    if (cnt_inc_s == BLINK_LAST) begin
                        blink_s = ~blink_r;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
                // armed is registered, so an Enter held at death never restarts at once.
                if (armed_r && (keycode == ENTER_KEY)) begin
                    state_s = ST_RESTART;
                    lives_s = LIVES_INIT;
                    cnt_s   = 8'd0;
                    armed_s = 1'b0;
                end else begin
                    armed_s = armed_r | (keycode != ENTER_KEY);
                end
            end
            ST_RESTART: begin
                state_s = ST_PLAY;
                lives_s = LIVES_INIT;
                cnt_s   = 8'd0;
                armed_s = 1'b0;
            end
            default: begin
                state_s = ST_PLAY;
                lives_s = LIVES_INIT;
                cnt_s   = 8'd0;
                armed_s = 1'b0;
                blink_s = 1'b0;
            end
        endcase
    end

    // Death_Text level while DEAD: blink phase with the feature, steady high otherwise.
    always_comb begin
        if (BLINK_EN) begin
            dead_text_s = blink_s;
        end else begin
            dead_text_s = 1'b1;
        end
    end

    // State registers and Moore outputs registered from the next state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r     <= ST_PLAY;
            lives       <= LIVES_INIT;
            cnt_r       <= 8'd0;
            armed_r     <= 1'b0;
            blink_r     <= 1'b0;
            Death_Text  <= 1'b0;
            game_active <= 1'b1;
            invuln      <= 1'b0;
            game_reset  <= 1'b0;
        end else begin
            state_r     <= state_s;
            lives       <= lives_s;
            cnt_r       <= cnt_s;
            armed_r     <= armed_s;
            blink_r     <= blink_s;
            Death_Text  <= (state_s == ST_DEAD) ? dead_text_s : 1'b0;
            game_active <= (state_s == ST_PLAY) || (state_s == ST_INVULN);
            invuln      <= (state_s == ST_INVULN);
            game_reset  <= (state_s == ST_RESTART);
        end
    end

endmodule

// File: tb/tb_death_screen_ctrl.sv
// Scoreboard bench for death_screen_ctrl with default parameters.
// Stimulus pushes the expected output word per cycle; a monitor pops and compares.

module tb_death_screen_ctrl;

    logic       CLK;
    logic       RESET;
    logic       frame_tick;
    logic       player_hit;
    logic [7:0] keycode;
    logic       Death_Text;
    logic       game_active;
    logic       invuln;
    logic       game_reset;
    logic [1:0] lives;

`ifdef DEATH_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif
    localparam int         BLINK = 30;
    localparam logic [7:0] KE    = 8'h28;
    localparam logic [7:0] KN    = 8'h00;

    typedef struct {
        logic [5:0] exp;
        string      nm;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;
    int   checks       = 0;
    int   errors       = 0;
    int   reset_pulses = 0;

    death_screen_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .frame_tick (frame_tick),
        .player_hit (player_hit),
        .keycode    (keycode),
        .Death_Text (Death_Text),
        .game_active(game_active),
        .invuln     (invuln),
        .game_reset (game_reset),
        .lives      (lives)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output word: {Death_Text, game_active, invuln, game_reset, lives}
    function automatic logic [5:0] ex(input logic dt, input logic ga, input logic iv,
                                      input logic gr, input logic [1:0] l);
        return {dt, ga, iv, gr, l};
    endfunction

    function automatic logic [5:0] play(input logic [1:0] l);
        return ex(1'b0, 1'b1, 1'b0, 1'b0, l);
    endfunction

    function automatic logic [5:0] inv(input logic [1:0] l);
        return ex(1'b0, 1'b1, 1'b1, 1'b0, l);
    endfunction

    function automatic logic [5:0] dead(input logic dt);
        return ex(dt, 1'b0, 1'b0, 1'b0, 2'd0);
    endfunction

    // Monitor: compare one queued expectation per clock, just after the edge.
    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            mon_r = q.pop_front();
            checks++;
            if ({Death_Text, game_active, invuln, game_reset, lives} !== mon_r.exp) begin
                errors++;
                $display("FAIL %s got dt/ga/iv/gr/lives=%b required=%b at %0t",
                         mon_r.nm, {Death_Text, game_active, invuln, game_reset, lives},
                         mon_r.exp, $time);
            end
        end
        if (game_reset === 1'b1) reset_pulses++;
    end

    task automatic cyc(input logic rst, input logic ft, input logic hit,
                       input logic [7:0] kc, input logic [5:0] e, input string nm);
        rec_t r;
        @(negedge CLK);
        RESET      = rst;
        frame_tick = ft;
        player_hit = hit;
        keycode    = kc;
        r.exp = e;
        r.nm  = nm;
        q.push_back(r);
    endtask

    // 60 ticks of immunity, then one spare tick back in PLAY.
    task automatic invuln_run(input logic [1:0] l);
        for (int k = 1; k <= 59; k++) cyc(1'b1, 1'b1, 1'b0, KN, inv(l), "inv_tick");
        cyc(1'b1, 1'b1, 1'b0, KN, play(l), "inv_exit_t60");
        cyc(1'b1, 1'b1, 1'b0, KN, play(l), "play_spare_tick");
    endtask

    // From PLAY with 3 lives, three hits lead into DYING.
    task automatic to_dying();
        cyc(1'b1, 1'b0, 1'b1, KN, inv(2'd2), "hit_a");
        invuln_run(2'd2);
        cyc(1'b1, 1'b0, 1'b1, KN, inv(2'd1), "hit_b");
        invuln_run(2'd1);
        cyc(1'b1, 1'b0, 1'b1, KN, dead(1'b0), "hit_fatal");
    endtask

    // 90 DYING ticks: text off through tick 89, DEAD with text on after tick 90.
    task automatic dying_run(input logic [7:0] kc);
        for (int k = 1; k <= 89; k++)
            cyc(1'b1, 1'b1, (k == 10) ? 1'b1 : 1'b0, kc, dead(1'b0), "dying_tick");
        cyc(1'b1, 1'b1, 1'b0, kc, dead(1'b1), "dying_to_dead_t90");
    endtask

    // DEAD ticks: text level follows the blink phase only when the feature is built.
    task automatic dead_ticks(input int n, input logic [7:0] kc);
        logic dt;
        for (int k = 1; k <= n; k++) begin
            dt = BLINK_ON ? (((k / BLINK) % 2) == 0) : 1'b1;
            cyc(1'b1, 1'b1, 1'b0, kc, dead(dt), "dead_tick");
        end
    endtask

    initial begin
        int exp_pulses;
        RESET      = 1'b0;
        frame_tick = 1'b0;
        player_hit = 1'b0;
        keycode    = KN;
        exp_pulses = 1;

        // Reset state and first hit, with stray hits inside INVULN
        cyc(1'b0, 1'b0, 1'b0, KN, play(2'd3), "reset");
        cyc(1'b1, 1'b0, 1'b0, KN, play(2'd3), "idle");
        cyc(1'b1, 1'b1, 1'b0, KN, play(2'd3), "play_tick");
        cyc(1'b1, 1'b1, 1'b1, KN, inv(2'd2), "hit1_with_tick");
        for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b1, 1'b0, KN, inv(2'd2), "inv_tick");
        cyc(1'b1, 1'b1, 1'b1, KN, inv(2'd2), "inv_hit_t5");
        cyc(1'b1, 1'b0, 1'b1, KN, inv(2'd2), "inv_hit_notick");
        for (int k = 6; k <= 59; k++) cyc(1'b1, 1'b1, 1'b0, KN, inv(2'd2), "inv_tick");
        cyc(1'b1, 1'b1, 1'b1, KN, play(2'd2), "inv_end_hit_t60");
        cyc(1'b1, 1'b1, 1'b0, KN, play(2'd2), "play_spare_tick");
        cyc(1'b1, 1'b0, 1'b1, KN, inv(2'd1), "hit2");
        invuln_run(2'd1);
        cyc(1'b1, 1'b0, 1'b1, KE, dead(1'b0), "hit3_fatal");

        // DYING with Enter already held, then DEAD without restart while held
        dying_run(KE);
        if (BLINK_ON) dead_ticks(65, KE);
        else          dead_ticks(5, KE);
        cyc(1'b1, 1'b0, 1'b0, KE, dead(1'b1), "dead_enter_held");
        cyc(1'b1, 1'b0, 1'b0, KN, dead(1'b1), "dead_arm");
        cyc(1'b1, 1'b0, 1'b0, KE, ex(1'b0, 1'b0, 1'b0, 1'b1, 2'd3), "restart_pulse");
        cyc(1'b1, 1'b0, 1'b0, KE, play(2'd3), "after_restart");
        cyc(1'b1, 1'b0, 1'b0, KE, play(2'd3), "enter_in_play");

        // Reset mid-DYING
        to_dying();
        for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b1, 1'b0, KE, dead(1'b0), "dying_tick");
        cyc(1'b0, 1'b1, 1'b1, KE, play(2'd3), "rst_mid_dying");
        cyc(1'b1, 1'b0, 1'b0, KE, play(2'd3), "post_rst_dying");

        // Reset mid-DEAD while armed and Enter pressed
        to_dying();
        dying_run(KN);
        cyc(1'b1, 1'b0, 1'b0, KN, dead(1'b1), "dead_idle");
        cyc(1'b0, 1'b0, 1'b0, KE, play(2'd3), "rst_mid_dead");
        cyc(1'b1, 1'b0, 1'b0, KE, play(2'd3), "post_rst_dead");

        // Armed Enter during the low blink phase
        if (BLINK_ON) begin
            exp_pulses = 2;
            to_dying();
            dying_run(KE);
            dead_ticks(30, KE);
            cyc(1'b1, 1'b0, 1'b0, KN, dead(1'b0), "blink_arm_low");
            cyc(1'b1, 1'b0, 1'b0, KE, ex(1'b0, 1'b0, 1'b0, 1'b1, 2'd3), "blink_restart");
            cyc(1'b1, 1'b0, 1'b0, KE, play(2'd3), "blink_after_restart");
        end

        repeat (3) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d pending required=0", q.size());
        end
        checks++;
        if (reset_pulses != exp_pulses) begin
            errors++;
            $display("FAIL reset_pulse_count got=%0d required=%0d", reset_pulses, exp_pulses);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
